// File: rtl/axis_byte_packer.sv
// Purpose : packs a byte-sparse AXI-Stream (contiguous-low tkeep per beat) into dense full-width beats.
// Latency : an accepted beat that completes an output beat is presented on m_* right after that edge.
// Backpr. : s_tready drops while a full beat waits on a stalled m_tready, or while a packet tail drains.
//
// Ports
//   clk, reset      single rising-edge clock; asynchronous active-low reset
//   s_tdata/s_tkeep/s_tvalid/s_tlast/s_tready   sparse input stream, byte 0 first
//   m_tdata/m_tkeep/m_tvalid/m_tlast/m_tready   dense output stream, unused lanes zero
//   pkt_cnt         count of tlast beats accepted downstream (wraps)
//   keep_err        sticky flag for an accepted beat with a non-contiguous s_tkeep
module axis_byte_packer #(
  parameter int NUM_BYTES = 32,
  parameter int FILL_W    = $clog2(2*NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] s_tdata,
  input  logic [NUM_BYTES-1:0]   s_tkeep,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [8*NUM_BYTES-1:0] m_tdata,
  output logic [NUM_BYTES-1:0]   m_tkeep,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [31:0]            pkt_cnt,
  output logic                   keep_err
);

  localparam int BUF_BYTES = 2*NUM_BYTES;
  localparam int BUF_W     = 8*BUF_BYTES;
  localparam logic [FILL_W-1:0] NB_F = FILL_W'(NUM_BYTES);

  // Mask with lanes 0..n-1 set.
  function automatic logic [NUM_BYTES-1:0] lo_mask(input logic [FILL_W-1:0] n);
    logic [NUM_BYTES-1:0] m;
    for (int i = 0; i < NUM_BYTES; i++) begin
      m[i] = (FILL_W'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [FILL_W-1:0] popcnt(input logic [NUM_BYTES-1:0] v);
    logic [FILL_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      c = c + FILL_W'(v[i]);
    end
    return c;
  endfunction

  // Registered state. The buffer holds valid bytes bottom-aligned; every
  // byte at or above fill_q is kept at zero so new input can be OR-merged.
  logic [BUF_W-1:0]  pack_buf_q;
  logic [FILL_W-1:0] fill_q;
  logic              last_pend_q;
  logic [31:0]       pkt_cnt_q;
  logic              keep_err_q;

  // Combinational next-state signals.
  logic [FILL_W-1:0]      beat_n;
  logic                   in_fire;
  logic                   out_fire;
  logic [FILL_W-1:0]      in_k;
  logic [NUM_BYTES-1:0]   in_lanes;
  logic                   keep_bad;
  logic [FILL_W-1:0]      pop_n;
  logic [FILL_W-1:0]      base;
  logic [FILL_W-1:0]      fill_d;
  logic [8*NUM_BYTES-1:0] ins_bytes;
  logic [BUF_W-1:0]       buf_d;
  logic                   last_pend_d;

  // Output side, driven purely from registered state.
  assign beat_n   = (fill_q >= NB_F) ? NB_F : fill_q;
  assign m_tvalid = (fill_q >= NB_F) | last_pend_q;
  assign m_tlast  = last_pend_q & (fill_q <= NB_F);
  assign m_tkeep  = lo_mask(beat_n);

  always_comb begin
    m_tdata = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      m_tdata[8*i +: 8] = m_tkeep[i] ? pack_buf_q[8*i +: 8] : 8'h00;
    end
  end

  // A tail in progress blocks input so packets never share a beat. While
  // fill < NUM_BYTES any input fits; otherwise a full beat must leave in
  // the same cycle to make room.
  assign s_tready = ~last_pend_q & ((fill_q < NB_F) | m_tready);

  assign in_fire  = s_tvalid & s_tready;
  assign out_fire = m_tvalid & m_tready;

  // Bytes are taken from the low popcount lanes regardless of mask shape,
  // so a malformed mask still moves a predictable number of bytes.
  assign in_k     = popcnt(s_tkeep);
  assign in_lanes = lo_mask(in_k);
  // A contiguous-low mask plus one has no bits in common with itself.
  assign keep_bad = (s_tkeep & (s_tkeep + NUM_BYTES'(1))) != '0;

  always_comb begin
    pop_n  = out_fire ? beat_n : '0;
    base   = fill_q - pop_n;
    fill_d = base + (in_fire ? in_k : '0);

    ins_bytes = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      ins_bytes[8*i +: 8] = (in_fire & in_lanes[i]) ? s_tdata[8*i +: 8] : 8'h00;
    end

    // base < NUM_BYTES whenever in_fire is high, so the write never spills.
    buf_d = (pack_buf_q >> {pop_n, 3'b000}) | (BUF_W'(ins_bytes) << {base, 3'b000});

    last_pend_d = last_pend_q;
    if (out_fire & m_tlast) begin
      last_pend_d = 1'b0;
    end else if (in_fire & s_tlast) begin
      last_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack_buf_q  <= '0;
      fill_q      <= '0;
      last_pend_q <= 1'b0;
      pkt_cnt_q   <= '0;
      keep_err_q  <= 1'b0;
    end else begin
      pack_buf_q  <= buf_d;
      fill_q      <= fill_d;
      last_pend_q <= last_pend_d;
      if (out_fire & m_tlast) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (in_fire & keep_bad) begin
        keep_err_q <= 1'b1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign keep_err = keep_err_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Purpose : self-checking bench for axis_byte_packer with a byte-queue reference model.
// Latency : expected beats are queued at stimulus time and popped by an output monitor.
// Backpr. : m_tready is driven always-on, random or held low depending on the phase.
module tb_axis_byte_packer;

  localparam int NB  = 32;
  localparam int DW  = 8*NB;
  localparam int CW  = DW + NB + 1;
  localparam int TMO = 1000;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  logic          clk;
  logic          reset;
  logic [DW-1:0] s_tdata;
  logic [NB-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [NB-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [31:0]   pkt_cnt;
  logic          keep_err;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;       // 0: always ready, 1: random, 2: held low
  int exp_pkt = 0;
  int tot_waits = 0;
  int t3_t = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] pk_dat[$];
  logic [NB-1:0] pk_keep[$];

  logic          hold_v = 1'b0;
  logic [CW-1:0] hold_beat;
  beat_t         mon_e;

  axis_byte_packer #(.NUM_BYTES(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .pkt_cnt  (pkt_cnt),
    .keep_err (keep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [NB-1:0] low_keep(input int k);
    logic [NB-1:0] m;
    for (int j = 0; j < NB; j++) m[j] = (j < k);
    return m;
  endfunction

  // Ready generator: changes only just after the rising edge.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every handshake and checks
  // that a stalled beat does not change.
  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", CW'(m_tvalid), CW'(1));
        chk("hold_stable", {m_tdata, m_tkeep, m_tlast}, hold_beat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {m_tdata, m_tkeep, m_tlast});
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_beat", {m_tdata, m_tkeep, m_tlast}, {mon_e.d, mon_e.k, mon_e.l});
        end
      end
      hold_v    = m_tvalid && !m_tready;
      hold_beat = {m_tdata, m_tkeep, m_tlast};
    end
  end

  // Reference model: gather the packet's valid bytes in stream order, then
  // cut them into NB-byte beats; an empty packet gives one empty tlast beat.
  // Afterwards drive the packet's beats onto s_*.
  task automatic send_pkt(input bit gaps);
    logic [7:0] bq[$];
    beat_t e;
    int n;
    int w;
    for (int b = 0; b < pk_dat.size(); b++) begin
      for (int j = 0; j < $countones(pk_keep[b]); j++) bq.push_back(pk_dat[b][8*j +: 8]);
    end
    if (bq.size() == 0) begin
      e.d = '0;
      e.k = '0;
      e.l = 1'b1;
      exp_q.push_back(e);
    end
    while (bq.size() > 0) begin
      n = (bq.size() < NB) ? bq.size() : NB;
      e.d = '0;
      e.k = '0;
      for (int j = 0; j < n; j++) begin
        e.d[8*j +: 8] = bq.pop_front();
        e.k[j] = 1'b1;
      end
      e.l = (bq.size() == 0);
      exp_q.push_back(e);
    end
    exp_pkt++;

    for (int b = 0; b < pk_dat.size(); b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tdata  = pk_dat[b];
      s_tkeep  = pk_keep[b];
      s_tlast  = (b == pk_dat.size() - 1);
      s_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < TMO) begin
        w++;
        @(negedge clk);
      end
      if (w >= TMO) begin
        checks++;
        errors++;
        $display("FAIL s_tready_timeout: got no ready in %0d cycles, expected ready", TMO);
      end
      tot_waits += w;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_valid", CW'(m_tvalid), CW'(0));
    chk("pkt_cnt", CW'(pkt_cnt), CW'(exp_pkt));
    @(posedge clk);
    #1;
  endtask

  // Three 20-byte beats carrying bytes 00..3B; lanes above 19 are junk.
  task automatic load_seq60();
    logic [DW-1:0] d;
    pk_dat.delete();
    pk_keep.delete();
    for (int b = 0; b < 3; b++) begin
      d = rand_data();
      for (int j = 0; j < 20; j++) d[8*j +: 8] = 8'(20*b + j);
      pk_dat.push_back(d);
      pk_keep.push_back(low_keep(20));
    end
  endtask

  task automatic run_random(input int npkt);
    int nb;
    int k;
    for (int p = 0; p < npkt; p++) begin
      pk_dat.delete();
      pk_keep.delete();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        k = $urandom_range(0, NB);
        if ($urandom_range(0, 2) == 0) k = NB;
        pk_dat.push_back(rand_data());
        pk_keep.push_back(low_keep(k));
      end
      send_pkt(1'b1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", CW'(m_tvalid), CW'(0));
    chk("rst_m_tlast", CW'(m_tlast), CW'(0));
    chk("rst_m_tkeep", CW'(m_tkeep), CW'(0));
    chk("rst_m_tdata", CW'(m_tdata), CW'(0));
    chk("rst_pkt_cnt", CW'(pkt_cnt), CW'(0));
    chk("rst_keep_err", CW'(keep_err), CW'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", CW'(s_tready), CW'(1));
    @(posedge clk);
    #1;

    // Two full beats at full rate.
    pk_dat.delete();
    pk_keep.delete();
    repeat (2) begin
      pk_dat.push_back(rand_data());
      pk_keep.push_back('1);
    end
    tot_waits = 0;
    send_pkt(1'b0);
    chk("t1_no_stall", CW'(tot_waits), CW'(0));
    drain();

    // 3 x 20 bytes -> one full beat and a 28-byte tail.
    load_seq60();
    send_pkt(1'b0);
    drain();

    // Same packet with the output stalled once data is waiting.
    load_seq60();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        send_pkt(1'b0);
      end
      begin
        t3_t = 0;
        @(negedge clk);
        while (!m_tvalid && t3_t < 200) begin
          t3_t++;
          @(negedge clk);
        end
        chk("t3_valid", CW'(m_tvalid), CW'(1));
        repeat (5) @(negedge clk);
        chk("t3_s_tready_low", CW'(s_tready), CW'(0));
        chk("t3_valid_held", CW'(m_tvalid), CW'(1));
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();

    // Empty packet.
    pk_dat.delete();
    pk_keep.delete();
    pk_dat.push_back(rand_data());
    pk_keep.push_back('0);
    send_pkt(1'b0);
    drain();

    // Random legal traffic with random backpressure.
    rdy_mode = 1;
    run_random(30);
    drain();
    rdy_mode = 0;
    chk("keep_err_clean", CW'(keep_err), CW'(0));

    // Non-contiguous mask: two bytes from lanes 0..1, error flagged.
    pk_dat.delete();
    pk_keep.delete();
    pk_dat.push_back(rand_data());
    pk_keep.push_back(NB'(5));
    send_pkt(1'b0);
    drain();
    chk("keep_err_set", CW'(keep_err), CW'(1));
    run_random(1);
    drain();
    chk("keep_err_sticky", CW'(keep_err), CW'(1));

    // Reset in the middle of a packet with data waiting on the output.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    pk_dat.delete();
    pk_keep.delete();
    s_tdata  = rand_data();
    s_tkeep  = low_keep(20);
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t5_fill20_no_valid", CW'(m_tvalid), CW'(0));
    @(posedge clk);
    #1;
    s_tdata  = rand_data();
    s_tkeep  = '1;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t5_full_valid", CW'(m_tvalid), CW'(1));
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", CW'(m_tvalid), CW'(0));
    chk("t5_rst_keep", CW'(m_tkeep), CW'(0));
    chk("t5_rst_data", CW'(m_tdata), CW'(0));
    chk("t5_rst_pkt_cnt", CW'(pkt_cnt), CW'(0));
    chk("t5_rst_keep_err", CW'(keep_err), CW'(0));
    exp_pkt = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    load_seq60();
    send_pkt(1'b0);
    drain();

    rdy_mode = 1;
    run_random(30);
    drain();
    chk("final_keep_err", CW'(keep_err), CW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
